// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU block.
//   alu_op_e : 5-bit opcode encoding, OP_ADD (0) through OP_GT (14).
//              Codes 15..31 are not enumerated and produce a zero result.
//   OP_W     : opcode width.
//   SHAMT_W  : width of the shift/rotate amount taken from B.
package alu_pkg;

  localparam int OP_W    = 5;
  localparam int SHAMT_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_SHL  = 5'd4,
    OP_SHR  = 5'd5,
    OP_ROL  = 5'd6,
    OP_ROR  = 5'd7,
    OP_AND  = 5'd8,
    OP_OR   = 5'd9,
    OP_XOR  = 5'd10,
    OP_NOR  = 5'd11,
    OP_NAND = 5'd12,
    OP_XNOR = 5'd13,
    OP_GT   = 5'd14
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter -- combinational shift/rotate datapath for the ALU.
// Ports:
//   op     : in  opcode; only OP_SHL/OP_SHR/OP_ROL/OP_ROR give a non-zero result
//   a      : in  WIDTH-bit operand
//   amt    : in  shift/rotate amount (B[4:0])
//   result : out 2*WIDTH-bit result
//            SHL keeps every bit shifted out of the low half (zero-extended
//            operand); SHR and the rotates use the low WIDTH bits only.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e              op,
  input  logic [WIDTH-1:0]     a,
  input  logic [SHAMT_W-1:0]   amt,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned WIDTH_U = WIDTH;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] a_dbl;
  logic [2*WIDTH-1:0] rol_full;
  logic [2*WIDTH-1:0] ror_full;
  int unsigned        rot_amt;

  // Rotates shift a doubled copy {a,a}: the upper half of a left shift is the
  // left rotation, the lower half of a right shift is the right rotation.
  // The amount is reduced modulo WIDTH so narrow builds still rotate cleanly.
  always_comb begin
    a_ext    = {{WIDTH{1'b0}}, a};
    a_dbl    = {a, a};
    rot_amt  = 32'(amt) % WIDTH_U;
    rol_full = a_dbl << rot_amt;
    ror_full = a_dbl >> rot_amt;
    result   = '0;
    case (op)
      OP_SHL:  result = a_ext << amt;
      OP_SHR:  result = a_ext >> amt;
      OP_ROL:  result = {{WIDTH{1'b0}}, rol_full[2*WIDTH-1:WIDTH]};
      OP_ROR:  result = {{WIDTH{1'b0}}, ror_full[WIDTH-1:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu -- registered single-cycle ALU, latency 1.
// Ports:
//   clk        : in  clock, all state on the rising edge
//   rst        : in  synchronous active-high reset, clears the outputs
//   A, B       : in  WIDTH-bit unsigned operands; B[4:0] is the shift amount
//   ALU_Select : in  5-bit opcode (alu_pkg::alu_op_e)
//   ALU_Out    : out 2*WIDTH-bit registered result
//   carry_out  : out ADD carry / SUB borrow, registered with ALU_Out;
//                present only when ALU_CARRY_OUT_EN is defined
// Interface timing: there is no valid/ready handshake. Operands and opcode
// are sampled on every rising edge and the result is visible after that edge;
// a new operation may be presented every cycle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [OP_W-1:0]      ALU_Select,
  output logic [2*WIDTH-1:0]   ALU_Out
`ifdef ALU_CARRY_OUT_EN
  ,
  output logic                 carry_out
`endif
);

  alu_op_e            op;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] shift_res;
  logic [2*WIDTH-1:0] result_d;

  assign op    = alu_op_e'(ALU_Select);
  assign a_ext = {{WIDTH{1'b0}}, A};
  assign b_ext = {{WIDTH{1'b0}}, B};

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .op     (op),
    .a      (A),
    .amt    (B[SHAMT_W-1:0]),
    .result (shift_res)
  );

  always_comb begin
    result_d = '0;
    case (op)
      OP_ADD:  result_d = a_ext + b_ext;
      // Subtraction at full 2*WIDTH width so A<B sign-extends into the upper half.
      OP_SUB:  result_d = a_ext - b_ext;
      OP_MUL:  result_d = a_ext * b_ext;
      OP_DIV: begin
        // Divide-by-zero: quotient saturates to all ones, remainder passes A.
        if (B == '0) result_d = {A, {WIDTH{1'b1}}};
        else         result_d = {A % B, A / B};
      end
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: result_d = shift_res;
      OP_AND:  result_d = {{WIDTH{1'b0}}, A & B};
      OP_OR:   result_d = {{WIDTH{1'b0}}, A | B};
      OP_XOR:  result_d = {{WIDTH{1'b0}}, A ^ B};
      OP_NOR:  result_d = {{WIDTH{1'b0}}, ~(A | B)};
      OP_NAND: result_d = {{WIDTH{1'b0}}, ~(A & B)};
      OP_XNOR: result_d = {{WIDTH{1'b0}}, ~(A ^ B)};
      OP_GT:   result_d = {{(2*WIDTH-1){1'b0}}, (A > B)};
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ALU_Out <= '0;
    else     ALU_Out <= result_d;
  end

`ifdef ALU_CARRY_OUT_EN
  logic carry_d;

  always_comb begin
    carry_d = 1'b0;
    case (op)
      OP_ADD:  carry_d = result_d[WIDTH];
      OP_SUB:  carry_d = (A < B);
      default: carry_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) carry_out <= 1'b0;
    else     carry_out <= carry_d;
  end
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu -- directed-vector bench for alu (WIDTH=32).
// Carry checks are compiled in only when ALU_CARRY_OUT_EN is defined.
module tb_alu;

  localparam int W = 32;

  logic            clk;
  logic            rst;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [4:0]      sel;
  logic [2*W-1:0]  alu_out;
`ifdef ALU_CARRY_OUT_EN
  logic            carry_out;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (a),
    .B          (b),
    .ALU_Select (sel),
    .ALU_Out    (alu_out)
`ifdef ALU_CARRY_OUT_EN
    ,
    .carry_out  (carry_out)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] got,
                       input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%h expected=0x%h", tag, got, exp);
    end
  endtask

  // Drive one operation, let it be sampled, then compare the registered
  // result against the queued expectation.
  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] exp, input logic exp_c);
    a   = av;
    b   = bv;
    sel = op;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(tag, alu_out, exp_q.pop_front());
`ifdef ALU_CARRY_OUT_EN
    check({tag, "_carry"}, {{(2*W-1){1'b0}}, carry_out}, {{(2*W-1){1'b0}}, exp_c});
`else
    if (exp_c === 1'bx) $display("unreachable");
`endif
  endtask

  initial begin
    rst = 1'b1;
    a   = 32'h5;
    b   = 32'h3;
    sel = 5'd0;
    @(posedge clk);
    #1;
    check("reset_out", alu_out, 64'h0);
`ifdef ALU_CARRY_OUT_EN
    check("reset_carry", {63'h0, carry_out}, 64'h0);
`endif
    rst = 1'b0;

    // basic ops, A=0x0A B=0x02
    run_op("add",  5'd0,  32'h0A, 32'h02, 64'hC, 1'b0);
    run_op("sub",  5'd1,  32'h0A, 32'h02, 64'h8, 1'b0);
    run_op("mul",  5'd2,  32'h0A, 32'h02, 64'h14, 1'b0);
    run_op("div",  5'd3,  32'h0A, 32'h02, 64'h5, 1'b0);
    run_op("shl",  5'd4,  32'h0A, 32'h02, 64'h28, 1'b0);
    run_op("shr",  5'd5,  32'h0A, 32'h02, 64'h2, 1'b0);
    run_op("rol",  5'd6,  32'h0A, 32'h02, 64'h28, 1'b0);
    run_op("ror",  5'd7,  32'h0A, 32'h02, 64'h80000002, 1'b0);
    run_op("and",  5'd8,  32'h0A, 32'h02, 64'h2, 1'b0);
    run_op("or",   5'd9,  32'h0A, 32'h02, 64'hA, 1'b0);
    run_op("xor",  5'd10, 32'h0A, 32'h02, 64'h8, 1'b0);
    run_op("nor",  5'd11, 32'h0A, 32'h02, 64'h00000000FFFFFFF5, 1'b0);
    run_op("nand", 5'd12, 32'h0A, 32'h02, 64'h00000000FFFFFFFD, 1'b0);
    run_op("xnor", 5'd13, 32'h0A, 32'h02, 64'h00000000FFFFFFF7, 1'b0);
    run_op("gt",   5'd14, 32'h0A, 32'h02, 64'h1, 1'b0);
    run_op("op20", 5'd20, 32'h0A, 32'h02, 64'h0, 1'b0);
    run_op("op15", 5'd15, 32'hFFFFFFFF, 32'h1, 64'h0, 1'b0);

    // arithmetic edges
    run_op("sub_pos",    5'd1, 32'hF6, 32'h0A, 64'hEC, 1'b0);
    run_op("sub_borrow", 5'd1, 32'h02, 32'h0A, 64'hFFFFFFFFFFFFFFF8, 1'b1);
    run_op("add_carry",  5'd0, 32'hFFFFFFFF, 32'h1, 64'h100000000, 1'b1);
    run_op("mul_max",    5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0);
    run_op("div_zero",   5'd3, 32'h7, 32'h0, 64'h00000007FFFFFFFF, 1'b0);
    run_op("div_rem",    5'd3, 32'd17, 32'd5, 64'h0000000200000003, 1'b0);
    run_op("gt_less",    5'd14, 32'h02, 32'h0A, 64'h0, 1'b0);
    run_op("gt_equal",   5'd14, 32'h55, 32'h55, 64'h0, 1'b0);

    // shift / rotate edges
    run_op("shl_wide",   5'd4, 32'hFFFFFFFF, 32'd31, 64'h7FFFFFFF80000000, 1'b0);
    run_op("shl_amtlow", 5'd4, 32'h1, 32'h21, 64'h2, 1'b0);
    run_op("shr_max",    5'd5, 32'h80000000, 32'd31, 64'h1, 1'b0);
    run_op("rol_wrap",   5'd6, 32'h80000001, 32'd4, 64'h18, 1'b0);
    run_op("ror_wrap",   5'd7, 32'h80000001, 32'd4, 64'h18000000, 1'b0);
    run_op("rol_zero",   5'd6, 32'h12345678, 32'd0, 64'h12345678, 1'b0);

    // reset in the middle of an ADD stream
    run_op("add_pre_rst", 5'd0, 32'h5, 32'h3, 64'h8, 1'b0);
    rst = 1'b1;
    a   = 32'hFFFFFFFF;
    b   = 32'h1;
    sel = 5'd0;
    @(posedge clk);
    #1;
    check("rst_mid_out", alu_out, 64'h0);
`ifdef ALU_CARRY_OUT_EN
    check("rst_mid_carry", {63'h0, carry_out}, 64'h0);
`endif
    rst = 1'b0;
    run_op("add_post_rst", 5'd0, 32'hFFFFFFFF, 32'h1, 64'h100000000, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width; ALU_Out is 2*WIDTH bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 A  input  WIDTH  SHALL be operand A, unsigned.
REQ-005 B  input  WIDTH  SHALL be operand B, unsigned; B[4:0] is the shift/rotate amount.
REQ-006 ALU_Select  input  5  SHALL be the opcode.
REQ-007 ALU_Out  output  2*WIDTH  SHALL be the registered result.

Function
REQ-008 ALU_Out SHALL update one cycle after A, B and ALU_Select are sampled on a rising clk edge; latency 1, no handshake, new operation accepted every cycle.
REQ-009 Logic results SHALL occupy the low WIDTH bits, with upper bits zero unless an opcode states otherwise.
REQ-010 Opcode 0 ADD: A+B zero-extended, carry in bit WIDTH.
REQ-011 Opcode 1 SUB: (zero-extended A) - (zero-extended B) modulo 2^(2*WIDTH); A<B yields upper bits all ones.
REQ-012 Opcode 2 MUL: full unsigned A*B product.
REQ-013 Opcode 3 DIV: quotient A/B in the low half, remainder A%B in the high half; B=0 gives quotient all ones and remainder A.
REQ-014 Opcode 4 SHL: zero-extended A shifted left by B[4:0], no bits lost.
REQ-015 Opcode 5 SHR: A logically shifted right by B[4:0].
REQ-016 Opcodes 6 ROL and 7 ROR: A rotated within WIDTH bits by B[4:0].
REQ-017 Opcodes 8 to 13 SHALL be AND, OR, XOR, NOR, NAND and XNOR of A and B, in that order.
REQ-018 Opcode 14 GT: 1 if A>B unsigned, else 0.
REQ-019 Opcodes 15 to 31: result 0.

Reset
REQ-020 When rst is high at a rising clk edge, ALU_Out (and carry_out if present) SHALL be 0 on that edge; any operation sampled that edge is discarded.
REQ-021 The first valid result SHALL appear one cycle after the first edge with rst low.

Configuration
REQ-022 With macro ALU_CARRY_OUT_EN defined, a 1-bit output carry_out SHALL exist, registered with ALU_Out.
REQ-023 carry_out SHALL be the ADD carry for opcode 0, the borrow (A<B) for opcode 1, and 0 otherwise.
REQ-024 Without ALU_CARRY_OUT_EN, the carry_out port and its logic SHALL be absent; ALU_Out SHALL be unchanged.

Structure
REQ-025 Package alu_pkg SHALL hold the opcode constants (OP_ADD through OP_GT) and the opcode typedef.
REQ-026 The shift/rotate datapath SHALL be a sub-module alu_shifter; all other logic lives in alu.

Verification
REQ-027 Cases with A=0x0A and B=0x02:
- ADD -> 0xC.
- SUB -> 0x8.
- MUL -> 0x14.
- DIV -> 0x5.
- SHL -> 0x28.
- SHR -> 0x2.
- ROL -> 0x28.
- ROR -> 0x80000002.
REQ-028 Logic cases with A=0x0A and B=0x02:
- AND -> 0x2.
- OR -> 0xA.
- XOR -> 0x8.
- NOR -> 0x00000000FFFFFFF5.
- NAND -> 0x00000000FFFFFFFD.
- XNOR -> 0x00000000FFFFFFF7.
- GT -> 1.
- Opcode 20 -> 0.
REQ-029 Arithmetic edge cases:
- A=0xF6, B=0x0A, SUB -> 0xEC.
- A=0x02, B=0x0A, SUB -> 0xFFFFFFFFFFFFFFF8, carry_out=1 (with macro).
- A=0xFFFFFFFF, B=1, ADD -> 0x100000000, carry_out=1.
REQ-030 A=0xFFFFFFFF, B=0xFFFFFFFF, MUL -> 0xFFFFFFFE00000001.
REQ-031 A=7, B=0, DIV -> 0x00000007FFFFFFFF.
REQ-032 rst asserted for one edge while ADD is in progress -> ALU_Out=0 on that edge; correct result one cycle after rst deasserts.
